imem_responder: RTL and testbench

- Instruction-memory responder serving the fetch stage's memory port.
- The fetch stage presents a word address and a clock-enable; this block returns the instruction word one cycle later and holds it while the enable is low, so stalls keep the instruction steady.
- Also contains a byte-stream boot loader (valid/ready) that fills the RAM sequentially before or between program runs.

---
 rtl/imem_responder_pkg.sv | 19 +
 rtl/imem_responder_if.sv | 27 ++
 rtl/imem_ram.sv | 24 ++
 rtl/imem_responder.sv | 146 ++++++++++++++
 tb/tb_imem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder and its
// neighbours in the fetch path.
package imem_responder_pkg;

  // addi x0,x0,0 -- the canonical RV32 NOP.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } ld_state_e;

  // The write index carries one extra bit so "past the end of RAM" is representable.
  function automatic int idx_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch read port and boot-loader byte stream of the instruction memory.
interface imem_responder_if #(
  parameter int AW = 10
);
  logic [31:0] rd_addr_i;
  logic        rd_cke_i;
  logic [31:0] rd_data_o;
  logic        ld_start_i;
  logic [7:0]  ld_data_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic        ld_last_i;
  logic        ld_busy_o;
  logic        ld_done_o;
  logic        ld_overflow_o;
  logic [AW:0] ld_count_o;

  modport master (
    output rd_addr_i, rd_cke_i, ld_start_i, ld_data_i, ld_valid_i, ld_last_i,
    input  rd_data_o, ld_ready_o, ld_busy_o, ld_done_o, ld_overflow_o, ld_count_o
  );

  modport slave (
    input  rd_addr_i, rd_cke_i, ld_start_i, ld_data_i, ld_valid_i, ld_last_i,
    output rd_data_o, ld_ready_o, ld_busy_o, ld_done_o, ld_overflow_o, ld_count_o
  );
endinterface

// File: rtl/imem_ram.sv
// Single-clock 1R1W synchronous RAM, read-first, no reset; kept separate so
// the storage maps cleanly onto block RAM.
module imem_ram #(
  parameter int AW     = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Both updates are non-blocking, so a same-word read returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory for the fetch stage: registered read port with stall
// hold, plus a byte-stream boot loader that packs bytes into words.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          AW        = 10,
  parameter int          LOAD_BASE = 0,
  parameter logic [31:0] NOP_WORD  = NOP_INSN
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);

  localparam int IW = idx_w(AW);

  ld_state_e     state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   asm_q, asm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          wr_req;
  logic [31:0]   wr_word;
  logic          we;

  logic          oor;
  logic          nop_sel_q;
  logic [31:0]   ram_q;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.rd_addr_i[1:0];
  assign oor             = |bus.rd_addr_i[31:AW+2];

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    wr_req  = 1'b0;
    wr_word = {8'h00, asm_q};

    case (state_q)
      IDLE: begin
        if (bus.ld_start_i) begin
          state_d = COLLECT;
          lane_d  = 2'd0;
          asm_d   = '0;
          idx_d   = IW'(LOAD_BASE);
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.ld_valid_i) begin
          if (lane_q == 2'd3) begin
            wr_req  = 1'b1;
            wr_word = {bus.ld_data_i, asm_q};
            asm_d   = '0;
            lane_d  = 2'd0;
            if (bus.ld_last_i) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            asm_d[{lane_q, 3'b000} +: 8] = bus.ld_data_i;
            lane_d = lane_q + 2'd1;
            if (bus.ld_last_i) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Unfilled upper bytes are already zero because asm is cleared per word.
        wr_req  = 1'b1;
        asm_d   = '0;
        lane_d  = 2'd0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The index saturates at 2^AW so every later word also counts as overflow.
    if (wr_req) begin
      if (idx_q[AW]) begin
        ovf_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
        cnt_d = cnt_q + (AW+1)'(1);
      end
    end
  end

  assign we = wr_req & ~idx_q[AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      asm_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Read stage: the NOP select travels with the RAM read and holds with it on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 nop_sel_q <= 1'b1;
    else if (bus.rd_cke_i)   nop_sel_q <= oor;
  end

  imem_ram #(
    .AW     (AW),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .re    (bus.rd_cke_i),
    .raddr (bus.rd_addr_i[AW+1:2]),
    .rdata (ram_q),
    .we    (we),
    .waddr (idx_q[AW-1:0]),
    .wdata (wr_word)
  );

  assign bus.rd_data_o     = nop_sel_q ? NOP_WORD : ram_q;
  assign bus.ld_ready_o    = (state_q == COLLECT);
  assign bus.ld_busy_o     = (state_q != IDLE);
  assign bus.ld_done_o     = done_q;
  assign bus.ld_overflow_o = ovf_q;
  assign bus.ld_count_o    = cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against a word-array reference model.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int          AW_A   = 10;
  localparam int          AW_B   = 2;
  localparam int          BASE_B = 3;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  imem_responder_if #(.AW(AW_A)) if_a ();
  imem_responder_if #(.AW(AW_B)) if_b ();

  imem_responder #(.AW(AW_A), .LOAD_BASE(0), .NOP_WORD(NOP)) dut_a (
    .clk (clk), .rst (rst_a), .bus (if_a.slave)
  );
  imem_responder #(.AW(AW_B), .LOAD_BASE(BASE_B), .NOP_WORD(NOP)) dut_b (
    .clk (clk), .rst (rst_b), .bus (if_b.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] mem_a [1024];
  logic [31:0] exp_rd_a;
  int          hi_a = 0;
  logic [7:0]  bq [$];

  // Pack the byte queue little-endian into words, zero-padding the tail.
  function automatic logic [31:0] word_of(input int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++)
      if (4*w + b < bq.size()) r[8*b +: 8] = bq[4*w + b];
    return r;
  endfunction

  task automatic load_a(input bit poke_start);
    int n, words;
    n = bq.size();
    words = (n + 3) / 4;
    for (int w = 0; w < words; w++) mem_a[w] = word_of(w);
    if (words > hi_a) hi_a = words;

    @(negedge clk);
    if_a.rd_cke_i   = 1'b0;
    if_a.ld_start_i = 1'b1;
    @(negedge clk);
    if_a.ld_start_i = 1'b0;
    check_eq("a_busy_after_start", if_a.ld_busy_o, 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if_a.ld_valid_i = 1'b1;
      if_a.ld_data_i  = bq[i];
      if_a.ld_last_i  = (i == n - 1);
      if_a.ld_start_i = poke_start && (i == n / 2) && (n > 1);
      check_eq("a_ready", if_a.ld_ready_o, 1);
      @(negedge clk);
      if_a.ld_valid_i = 1'b0;
      if_a.ld_last_i  = 1'b0;
      if_a.ld_start_i = 1'b0;
    end
    if (n % 4 != 0) begin
      check_eq("a_flush_busy", {if_a.ld_busy_o, if_a.ld_done_o, if_a.ld_ready_o}, 3'b100);
      @(negedge clk);
    end
    check_eq("a_done_busy", {if_a.ld_done_o, if_a.ld_busy_o}, 2'b10);
    check_eq("a_count", if_a.ld_count_o, words);
    check_eq("a_ovf", if_a.ld_overflow_o, 0);
    @(negedge clk);
    check_eq("a_done_pulse", if_a.ld_done_o, 0);
  endtask

  task automatic read_a(input logic [31:0] addr, input bit cke);
    if_a.rd_addr_i = addr;
    if_a.rd_cke_i  = cke;
    @(negedge clk);
    if (cke) exp_rd_a = (addr[31:AW_A+2] != 0) ? NOP : mem_a[addr[AW_A+1:2]];
    check_eq("a_rd_data", if_a.rd_data_o, exp_rd_a);
  endtask

  task automatic read_b(input logic [31:0] addr, input logic [31:0] exp);
    if_b.rd_addr_i = addr;
    if_b.rd_cke_i  = 1'b1;
    @(negedge clk);
    check_eq("b_rd_data", if_b.rd_data_o, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wb;
    {if_a.ld_start_i, if_a.ld_valid_i, if_a.ld_last_i, if_a.ld_data_i} = '0;
    {if_b.ld_start_i, if_b.ld_valid_i, if_b.ld_last_i, if_b.ld_data_i} = '0;
    if_a.rd_addr_i = '0; if_a.rd_cke_i = 1'b1;
    if_b.rd_addr_i = '0; if_b.rd_cke_i = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_rd_data", if_a.rd_data_o, NOP);
    check_eq("rst_ctrl", {if_a.ld_ready_o, if_a.ld_busy_o, if_a.ld_done_o, if_a.ld_overflow_o}, 0);
    check_eq("rst_count", if_a.ld_count_o, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    exp_rd_a = NOP;
    if_a.rd_cke_i = 1'b0;
    @(negedge clk);

    // Directed loads
    bq = '{8'h13, 8'h05, 8'h10, 8'h00};
    load_a(1'b0);
    read_a(32'h0, 1'b1);
    check_eq("word0_lit", if_a.rd_data_o, 32'h0010_0513);

    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load_a(1'b0);
    read_a(32'h0, 1'b1);
    check_eq("word0_b_lit", if_a.rd_data_o, 32'hDDCC_BBAA);
    read_a(32'h4, 1'b1);
    check_eq("word1_flush_lit", if_a.rd_data_o, 32'h0000_2211);

    // Stall hold
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    load_a(1'b1);
    read_a(32'h4, 1'b1);
    for (int i = 0; i < 3; i++) read_a(32'h8, 1'b0);
    read_a(32'h8, 1'b1);
    read_a(32'h0000_1000, 1'b1);
    check_eq("oor_lit", if_a.rd_data_o, NOP);

    // Random sessions and reads
    for (int s = 0; s < 8; s++) begin
      bq.delete();
      repeat ($urandom_range(1, 24)) bq.push_back(8'($urandom));
      load_a(1'($urandom_range(0, 1)));
      for (int r = 0; r < 10; r++) begin
        if ($urandom_range(0, 3) == 0)
          read_a({20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)}, 1'($urandom_range(0, 3) != 0));
        else
          read_a({20'h0, 10'($urandom_range(0, hi_a - 1)), 2'($urandom)}, 1'($urandom_range(0, 3) != 0));
      end
    end

    // Small RAM starting at its last word: second word falls off the end
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    wb = word_of(0);
    @(negedge clk);
    if_b.ld_start_i = 1'b1;
    @(negedge clk);
    if_b.ld_start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if_b.ld_valid_i = 1'b1;
      if_b.ld_data_i  = bq[i];
      if_b.ld_last_i  = (i == 7);
      check_eq("b_ready", if_b.ld_ready_o, 1);
      @(negedge clk);
    end
    if_b.ld_valid_i = 1'b0;
    if_b.ld_last_i  = 1'b0;
    check_eq("b_done_busy", {if_b.ld_done_o, if_b.ld_busy_o}, 2'b10);
    check_eq("b_count", if_b.ld_count_o, 1);
    check_eq("b_ovf", if_b.ld_overflow_o, 1);
    read_b(32'hC, wb);
    read_b(32'h10, NOP);

    // Reset in the middle of a session
    if_b.ld_start_i = 1'b1;
    @(negedge clk);
    if_b.ld_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_b.ld_valid_i = 1'b1;
      if_b.ld_data_i  = 8'($urandom);
      @(negedge clk);
    end
    if_b.ld_valid_i = 1'b0;
    rst_b = 1'b1;
    #1;
    check_eq("b_rst_busy", if_b.ld_busy_o, 0);
    check_eq("b_rst_rd", if_b.rd_data_o, NOP);
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("b_rst_no_done", {if_b.ld_done_o, if_b.ld_busy_o, if_b.ld_overflow_o}, 0);
      @(negedge clk);
    end
    check_eq("b_rst_count", if_b.ld_count_o, 0);
    read_b(32'hC, wb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
